// File: rtl/sorter7_pkg.sv
// sorter7_pkg: shared constants and types for the sorter7 stream controller.
//   WIN_LEN        sliding window length (sorter7 has seven inputs)
//   CENTER_IDX     window slot holding the sample being judged
//   FLUSH_LEN      bubble shifts needed to drain a line's tail
//   DATA_WIDTH_DEF default sample width
package sorter7_pkg;

    localparam int unsigned WIN_LEN        = 7;
    localparam int unsigned CENTER_IDX     = 3;
    localparam int unsigned FLUSH_LEN      = 3;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic {RUN, FLUSH} state_t;

    typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/sorter7_window.sv
// sorter7_window: 7-slot sample shift register with a per-slot valid mask.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   shift         advance the window by one slot this cycle
//   bubble        the shifted-in slot is a flush bubble (mask bit 0)
//   clear         zero the whole mask on this shift (end of a line flush)
//   din           value entering slot 0
//   taps          slots 0..5 (slot 0 newest), used as sorter inputs 2..7
//   center_valid  mask bit of the slot that becomes the centre on the next shift
//   full          mask will be all ones after this cycle's shift
module sorter7_window
    import sorter7_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 shift,
    input  logic                                 bubble,
    input  logic                                 clear,
    input  logic [DATA_WIDTH-1:0]                din,
    output logic [WIN_LEN-2:0][DATA_WIDTH-1:0]   taps,
    output logic                                 center_valid,
    output logic                                 full
);

    logic [WIN_LEN-1:0][DATA_WIDTH-1:0] w;
    logic [WIN_LEN-1:0]                 m;

    always_ff @(posedge clk) begin
        if (rst) begin
            w <= '0;
            m <= '0;
        end else if (shift) begin
            w <= {w[WIN_LEN-2:0], din};
            m <= clear ? '0 : {m[WIN_LEN-2:0], !bubble};
        end
    end

    assign taps         = w[WIN_LEN-2:0];
    assign center_valid = m[CENTER_IDX-1];
    // Post-shift view: the sorter sees the next window, so "full" must too.
    assign full         = (&m[WIN_LEN-2:0]) && !bubble;

    // The oldest slot falls off the sorter; it is kept only to complete the window.
    logic unused_tail;
    assign unused_tail = ^{w[WIN_LEN-1], m[WIN_LEN-1]};

endmodule

// File: rtl/sorter7_stream_ctrl.sv
// sorter7_stream_ctrl: impulse-noise filter sequencing an external sorter7
// over a line-based sample stream.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_data/in_valid/in_ready   input sample stream, in_last marks end of line
//   out_data/out_valid/out_ready filtered output stream
//   out_noise                   out_data is a median replacement
//   srt_1..srt_7                sorter inputs (srt_1 newest), next window
//   srt_min/srt_med/srt_max     combinational sorter results
//   noise_cnt                   saturating count of replaced samples
//                               (only when NOISE_STATS_EN is defined)
module sorter7_stream_ctrl
    import sorter7_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned NOISE_THRESH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_noise,
`ifdef NOISE_STATS_EN
    output logic [15:0]           noise_cnt,
`endif
    output logic [DATA_WIDTH-1:0] srt_1,
    output logic [DATA_WIDTH-1:0] srt_2,
    output logic [DATA_WIDTH-1:0] srt_3,
    output logic [DATA_WIDTH-1:0] srt_4,
    output logic [DATA_WIDTH-1:0] srt_5,
    output logic [DATA_WIDTH-1:0] srt_6,
    output logic [DATA_WIDTH-1:0] srt_7,
    input  logic [DATA_WIDTH-1:0] srt_min,
    input  logic [DATA_WIDTH-1:0] srt_med,
    input  logic [DATA_WIDTH-1:0] srt_max
);

    localparam logic [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(NOISE_THRESH);

    state_t                            state, state_next;
    logic [1:0]                        flush_cnt, flush_cnt_next;
    logic                              adv, accept, bubble, shift, win_clear;
    logic                              center_valid, full, noise;
    logic [DATA_WIDTH-1:0]             incoming, center, spread;
    logic [WIN_LEN-2:0][DATA_WIDTH-1:0] taps;

    assign adv      = !out_valid || out_ready;
    assign in_ready = (state == RUN) && adv && !rst;
    assign accept   = in_valid && in_ready;
    assign bubble   = (state == FLUSH);
    assign shift    = accept || (bubble && adv);
    assign incoming = bubble ? '0 : in_data;

    sorter7_window #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_window (
        .clk          (clk),
        .rst          (rst),
        .shift        (shift),
        .bubble       (bubble),
        .clear        (win_clear),
        .din          (incoming),
        .taps         (taps),
        .center_valid (center_valid),
        .full         (full)
    );

    // Sorter always sees the window as it will be after this cycle's shift.
    assign srt_1 = incoming;
    assign srt_2 = taps[0];
    assign srt_3 = taps[1];
    assign srt_4 = taps[2];
    assign srt_5 = taps[3];
    assign srt_6 = taps[4];
    assign srt_7 = taps[5];

    // Slot 2 moves into the centre slot on the shift.
    assign center = taps[CENTER_IDX-1];
    assign spread = srt_max - srt_min;
    assign noise  = full && ((center == srt_min) || (center == srt_max)) && (spread >= THRESH);

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        win_clear      = 1'b0;
        case (state)
            RUN: begin
                if (accept && in_last) begin
                    state_next     = FLUSH;
                    flush_cnt_next = '0;
                end
            end
            FLUSH: begin
                if (adv) begin
                    if (flush_cnt == 2'(FLUSH_LEN - 1)) begin
                        state_next     = RUN;
                        flush_cnt_next = '0;
                        win_clear      = 1'b1;
                    end else begin
                        flush_cnt_next = flush_cnt + 2'd1;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_noise <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
            if (shift && center_valid) begin
                out_valid <= 1'b1;
                out_data  <= noise ? srt_med : center;
                out_noise <= noise;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NOISE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            noise_cnt <= '0;
        end else if (shift && center_valid && noise && (noise_cnt != 16'hFFFF)) begin
            noise_cnt <= noise_cnt + 16'd1;
        end
    end
`else
    // Statistics counter not built.
`endif

endmodule

// File: tb/tb_sorter7_stream_ctrl.sv
module tb_sorter7_stream_ctrl;
    import sorter7_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    rst, in_valid, in_last, out_ready;
    sample_t in_data;

    logic    in_ready, out_valid, out_noise;
    sample_t out_data, s1, s2, s3, s4, s5, s6, s7, smin, smed, smax;
    logic    in_ready_b, out_valid_b, out_noise_b;
    sample_t out_data_b, b1, b2, b3, b4, b5, b6, b7, bmin, bmed, bmax;
`ifdef NOISE_STATS_EN
    logic [15:0] noise_cnt, noise_cnt_b;
`endif

    sorter7_stream_ctrl #(.DATA_WIDTH(8), .NOISE_THRESH(32)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_noise(out_noise),
`ifdef NOISE_STATS_EN
        .noise_cnt(noise_cnt),
`endif
        .srt_1(s1), .srt_2(s2), .srt_3(s3), .srt_4(s4), .srt_5(s5), .srt_6(s6), .srt_7(s7),
        .srt_min(smin), .srt_med(smed), .srt_max(smax)
    );

    sorter7_stream_ctrl #(.DATA_WIDTH(8), .NOISE_THRESH(16)) dut16 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_last(in_last), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_noise(out_noise_b),
`ifdef NOISE_STATS_EN
        .noise_cnt(noise_cnt_b),
`endif
        .srt_1(b1), .srt_2(b2), .srt_3(b3), .srt_4(b4), .srt_5(b5), .srt_6(b6), .srt_7(b7),
        .srt_min(bmin), .srt_med(bmed), .srt_max(bmax)
    );

    // Reference sorter7: returns {min, med, max}.
    function automatic logic [23:0] sort7(input sample_t a1, input sample_t a2,
                                          input sample_t a3, input sample_t a4,
                                          input sample_t a5, input sample_t a6,
                                          input sample_t a7);
        sample_t v[7];
        sample_t t;
        v[0] = a1; v[1] = a2; v[2] = a3; v[3] = a4; v[4] = a5; v[5] = a6; v[6] = a7;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6 - i; j++) begin
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
            end
        end
        return {v[0], v[3], v[6]};
    endfunction

    always_comb {smin, smed, smax} = sort7(s1, s2, s3, s4, s5, s6, s7);
    always_comb {bmin, bmed, bmax} = sort7(b1, b2, b3, b4, b5, b6, b7);

    int      tests = 0;
    int      fails = 0;
    int      exp_cnt = 0;
    sample_t vin[16];
    sample_t got_d[$];
    logic    got_n[$];
    sample_t got16_d[$];
    logic    got16_n[$];
    sample_t srt_snap[7];
    int      stall_obs, stall_ready_bad, stall_data_bad;
    bit      timed_out;

    // Drives one line of n samples from vin[] and collects outputs until n arrive.
    task automatic drive_line(input int n, input int stall_from, input int stall_len);
        int      idx = 0;
        int      cyc = 0;
        bit      in_stall;
        bit      have_held = 0;
        sample_t held;
        got_d.delete(); got_n.delete(); got16_d.delete(); got16_n.delete();
        stall_obs = 0; stall_ready_bad = 0; stall_data_bad = 0; timed_out = 0;
        while (got_d.size() < n) begin
            if (cyc >= 200) begin
                timed_out = 1;
                break;
            end
            in_stall  = (cyc >= stall_from) && (cyc < stall_from + stall_len);
            out_ready = !in_stall;
            in_valid  = (idx < n);
            in_data   = (idx < n) ? vin[idx] : 8'd0;
            in_last   = (idx == n - 1);
            #1;
            if (in_stall && out_valid) begin
                stall_obs++;
                if (in_ready !== 1'b0) stall_ready_bad++;
                if (have_held && out_data !== held) stall_data_bad++;
                held = out_data;
                have_held = 1;
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_n.push_back(out_noise);
            end
            if (out_valid_b && out_ready) begin
                got16_d.push_back(out_data_b);
                got16_n.push_back(out_noise_b);
            end
            if (in_valid && in_ready) begin
                if (idx == n - 1) begin
                    srt_snap[0] = s1; srt_snap[1] = s2; srt_snap[2] = s3; srt_snap[3] = s4;
                    srt_snap[4] = s5; srt_snap[5] = s6; srt_snap[6] = s7;
                end
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        tests++;
        if (out_data !== 8'd0) begin
            fails++; $display("FAIL reset_out_data: got %0d expected 0", out_data);
        end
        tests++;
        if (out_noise !== 1'b0) begin
            fails++; $display("FAIL reset_out_noise: got %0b expected 0", out_noise);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready_in_rst: got %0b expected 0", in_ready);
        end
`ifdef NOISE_STATS_EN
        tests++;
        if (noise_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_noise_cnt: got %0d expected 0", noise_cnt);
        end
`endif
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready_after: got %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough();
        sample_t d[7] = '{8'd10, 8'd30, 8'd20, 8'd50, 8'd44, 8'd100, 8'd70};
        foreach (d[i]) vin[i] = d[i];
        drive_line(7, 1000, 0);
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL pass_timeout: got %0d outputs expected 7", got_d.size());
        end
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (got_d[i] !== d[i] || got_n[i] !== 1'b0) begin
                fails++;
                $display("FAIL pass_out[%0d]: got %0d/noise %0b expected %0d/noise 0",
                         i, got_d[i], got_n[i], d[i]);
            end
        end
        // Sorter drive on accepting the last sample: srt_1 newest .. srt_7 oldest.
        for (int j = 0; j < 7; j++) begin
            tests++;
            if (srt_snap[j] !== d[6-j]) begin
                fails++;
                $display("FAIL pass_srt_%0d: got %0d expected %0d", j + 1, srt_snap[j], d[6-j]);
            end
        end
    endtask

    task automatic test_impulse(input int stall_from, input int stall_len);
        sample_t d[7] = '{8'd10, 8'd12, 8'd11, 8'd255, 8'd13, 8'd12, 8'd11};
        sample_t e[7] = '{8'd10, 8'd12, 8'd11, 8'd12, 8'd13, 8'd12, 8'd11};
        foreach (d[i]) vin[i] = d[i];
        drive_line(7, stall_from, stall_len);
        exp_cnt++;
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL impulse_timeout: got %0d outputs expected 7", got_d.size());
        end
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (got_d[i] !== e[i] || got_n[i] !== (i == 3)) begin
                fails++;
                $display("FAIL impulse_out[%0d]: got %0d/noise %0b expected %0d/noise %0b",
                         i, got_d[i], got_n[i], e[i], (i == 3));
            end
        end
        if (stall_len > 0) begin
            tests++;
            if (stall_obs != stall_len) begin
                fails++; $display("FAIL stall_cycles: got %0d expected %0d", stall_obs, stall_len);
            end
            tests++;
            if (stall_ready_bad != 0) begin
                fails++; $display("FAIL stall_in_ready: got %0d high cycles expected 0",
                                  stall_ready_bad);
            end
            tests++;
            if (stall_data_bad != 0) begin
                fails++; $display("FAIL stall_out_data: got %0d changes expected 0",
                                  stall_data_bad);
            end
        end
`ifdef NOISE_STATS_EN
        tests++;
        if (noise_cnt !== 16'(exp_cnt)) begin
            fails++; $display("FAIL impulse_noise_cnt: got %0d expected %0d", noise_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic test_thresh();
        sample_t d[7] = '{8'd100, 8'd100, 8'd100, 8'd120, 8'd100, 8'd100, 8'd100};
        foreach (d[i]) vin[i] = d[i];
        drive_line(7, 1000, 0);
        tests++;
        if (timed_out || got16_d.size() != 7) begin
            fails++; $display("FAIL thresh_count: got %0d/%0d outputs expected 7/7",
                              got_d.size(), got16_d.size());
        end
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (got_d[i] !== d[i] || got_n[i] !== 1'b0) begin
                fails++;
                $display("FAIL thresh32_out[%0d]: got %0d/noise %0b expected %0d/noise 0",
                         i, got_d[i], got_n[i], d[i]);
            end
            tests++;
            if (got16_d[i] !== 8'd100 || got16_n[i] !== (i == 3)) begin
                fails++;
                $display("FAIL thresh16_out[%0d]: got %0d/noise %0b expected 100/noise %0b",
                         i, got16_d[i], got16_n[i], (i == 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        vin[0] = 8'd5; vin[1] = 8'd6; vin[2] = 8'd7;
        drive_line(3, 1000, 0);
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL short_timeout: got %0d outputs expected 3", got_d.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_d[i] !== 8'(5 + i) || got_n[i] !== 1'b0) begin
                fails++; $display("FAIL short_out[%0d]: got %0d/noise %0b expected %0d/noise 0",
                                  i, got_d[i], got_n[i], 5 + i);
            end
        end
        for (int i = 0; i < 9; i++) vin[i] = 8'(i + 1);
        drive_line(9, 1000, 0);
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL b2b_timeout: got %0d outputs expected 9", got_d.size());
        end
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (got_d[i] !== 8'(i + 1) || got_n[i] !== 1'b0) begin
                fails++; $display("FAIL b2b_out[%0d]: got %0d/noise %0b expected %0d/noise 0",
                                  i, got_d[i], got_n[i], i + 1);
            end
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(5 + i); in_last = (i == 2); out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk);  // first bubble shift, loads the first output
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL rstflush_in_ready_in_rst: got %0b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'd0) begin
            fails++; $display("FAIL rstflush_out: got valid %0b data %0d expected valid 0 data 0",
                              out_valid, out_data);
        end
`ifdef NOISE_STATS_EN
        exp_cnt = 0;
        tests++;
        if (noise_cnt !== 16'd0) begin
            fails++; $display("FAIL rstflush_noise_cnt: got %0d expected 0", noise_cnt);
        end
`endif
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL rstflush_in_ready_after: got %0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) vin[i] = 8'(20 + i);
        drive_line(9, 1000, 0);
        tests++;
        if (timed_out) begin
            fails++; $display("FAIL rstflush_timeout: got %0d outputs expected 9", got_d.size());
        end
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (got_d[i] !== 8'(20 + i)) begin
                fails++; $display("FAIL rstflush_out[%0d]: got %0d expected %0d",
                                  i, got_d[i], 20 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_impulse(1000, 0);
        test_thresh();
        test_impulse(6, 5);
        test_back_to_back();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
